// File: rtl/gameplay_pkg.sv
// Constants and state encoding shared by the gameplay datapath, control FSM,
// block renderer and VGA adapter wrapper.
package gameplay_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ERASE,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/rect_sweeper.sv
// Raster counter over a width x height rectangle: cx inner, cy outer.
// last flags the final pixel of the sweep; counters wrap to zero after it.
module rect_sweeper
    import gameplay_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    input  logic           load,
    input  logic           enable,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic row_end;

    assign row_end = (cx == width - X_W'(1));
    assign last    = enable && row_end && (cy == height - Y_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (load || last) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (row_end) begin
                cx <= '0;
                cy <= cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/block_renderer.sv
// Draws a filled block (optionally erasing the previous one) or clears the
// whole screen, one pixel per clock into the VGA adapter's write port.
module block_renderer
    import gameplay_pkg::*;
#(
    parameter int                  BLOCK_W   = 20,
    parameter int                  BLOCK_H   = 4,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                clear,
    input  logic                erase_en,
    input  logic [X_W-1:0]      curr_x_position,
    input  logic [Y_W-1:0]      curr_y_position,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    state_t state, next_state;

    logic [X_W-1:0]      lat_x, prev_x, ext_w, cx, base_x;
    logic [Y_W-1:0]      lat_y, prev_y, ext_h, cy, base_y;
    logic [COLOUR_W-1:0] lat_colour;
    logic                prev_valid, load, sweeping, last;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;

    assign sweeping = (state == CLEAR) || (state == ERASE) || (state == DRAW);
    assign ext_w    = (state == CLEAR) ? X_W'(SCREEN_W) : X_W'(BLOCK_W);
    assign ext_h    = (state == CLEAR) ? Y_W'(SCREEN_H) : Y_W'(BLOCK_H);

    rect_sweeper u_sweeper (
        .clk    (clk),
        .resetn (resetn),
        .width  (ext_w),
        .height (ext_h),
        .load   (load),
        .enable (sweeping),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_colour <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            state <= next_state;
            // clear has priority: a coincident start is dropped entirely
            if (state == IDLE && clear) begin
                prev_valid <= 1'b0;
            end else if (state == IDLE && start) begin
                lat_x      <= curr_x_position;
                lat_y      <= curr_y_position;
                lat_colour <= colour_in;
            end
            if (state == DRAW && last) begin
                prev_x     <= lat_x;
                prev_y     <= lat_y;
                prev_valid <= 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    next_state = CLEAR;
                    load       = 1'b1;
                end else if (start) begin
                    next_state = (erase_en && prev_valid) ? ERASE : DRAW;
                    load       = 1'b1;
                end
            end
            CLEAR:   if (last) next_state = DONE;
            ERASE:   if (last) next_state = DRAW;
            DRAW:    if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        base_x     = '0;
        base_y     = '0;
        vga_colour = '0;
        unique case (state)
            CLEAR: vga_colour = BG_COLOUR;
            ERASE: begin
                base_x     = prev_x;
                base_y     = prev_y;
                vga_colour = BG_COLOUR;
            end
            DRAW: begin
                base_x     = lat_x;
                base_y     = lat_y;
                vga_colour = lat_colour;
            end
            default: ;
        endcase
    end

    // Off-screen pixels keep their slot in the sweep but are not written
    assign sum_x    = {1'b0, base_x} + {1'b0, cx};
    assign sum_y    = {1'b0, base_y} + {1'b0, cy};
    assign vga_x    = sweeping ? sum_x[X_W-1:0] : '0;
    assign vga_y    = sweeping ? sum_y[Y_W-1:0] : '0;
    assign vga_plot = sweeping && (sum_x < (X_W+1)'(SCREEN_W))
                               && (sum_y < (Y_W+1)'(SCREEN_H));
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_block_renderer.sv
// Self-checking bench for block_renderer: command table plus reset corner case,
// with every plotted pixel compared against a queue of expected pixels.
module tb_block_renderer;

    logic       clk = 1'b0;
    logic       resetn, start, clear, erase_en;
    logic [7:0] curr_x_position, vga_x;
    logic [6:0] curr_y_position, vga_y;
    logic [2:0] colour_in, vga_colour;
    logic       busy, done, vga_plot;

    block_renderer dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .clear           (clear),
        .erase_en        (erase_en),
        .curr_x_position (curr_x_position),
        .curr_y_position (curr_y_position),
        .colour_in       (colour_in),
        .busy            (busy),
        .done            (done),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_colour      (vga_colour),
        .vga_plot        (vga_plot)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       start;
        logic       clear;
        logic       erase;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        int         inject;
        int         lat;
        int         plots;
    } vec_t;

    vec_t        vecs[7];
    logic [17:0] exp_q[$];
    logic [17:0] exp_pix;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          plot_cnt = 0;
    int          done_cnt = 0;
    logic        m_valid  = 1'b0;
    int          m_px     = 0;
    int          m_py     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (vga_plot === 1'b1) begin
            plot_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pixel_extra: got %0d,%0d expected no plot at %0t", vga_x, vga_y, $time);
            end else begin
                exp_pix = exp_q.pop_front();
                check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_pix});
            end
        end
    end

    task automatic push_rect(input int bx, input int by, input int w, input int h, input logic [2:0] col);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int sx = bx + c;
                int sy = by + r;
                if (sx < 160 && sy < 120) exp_q.push_back({sx[7:0], sy[6:0], col});
            end
        end
    endtask

    task automatic model(input vec_t v);
        if (v.clear) begin
            push_rect(0, 0, 160, 120, 3'b000);
            m_valid = 1'b0;
        end else if (v.start) begin
            if (v.erase && m_valid) push_rect(m_px, m_py, 20, 4, 3'b000);
            push_rect(int'(v.x), int'(v.y), 20, 4, v.col);
            m_px    = int'(v.x);
            m_py    = int'(v.y);
            m_valid = 1'b1;
        end
    endtask

    task automatic run_cmd(input vec_t v, input string name);
        int n, p0, d0;
        model(v);
        @(negedge clk);
        start = v.start; clear = v.clear; erase_en = v.erase;
        curr_x_position = v.x; curr_y_position = v.y; colour_in = v.col;
        p0 = plot_cnt; d0 = done_cnt;
        @(negedge clk);
        start = 1'b0; clear = 1'b0; erase_en = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 25000) begin
            if (n == v.inject) begin
                start = 1'b1; erase_en = 1'b1;
                curr_x_position = 8'd100; curr_y_position = 7'd60; colour_in = 3'b111;
            end else begin
                start = 1'b0; erase_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, n, v.lat);
        @(negedge clk);
        check({name, "_busy_low"}, {31'd0, busy}, 0);
        check({name, "_plots"}, plot_cnt - p0, v.plots);
        check({name, "_done_count"}, done_cnt - d0, 1);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        vec_t v;
        resetn = 1'b0; start = 1'b0; clear = 1'b0; erase_en = 1'b0;
        curr_x_position = '0; curr_y_position = '0; colour_in = '0;

        //            start clear erase  x       y      col     inj lat    plots
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd40,  7'd100, 3'b100, 0, 81,    80};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'd50,  7'd96,  3'b010, 0, 161,   160};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd150, 7'd118, 3'b001, 0, 81,    20};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd60,  7'd50,  3'b011, 10, 81,   80};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'd30,  7'd10,  3'b110, 0, 161,   160};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 8'd5,   7'd5,   3'b111, 0, 19201, 19200};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'd10,  7'd20,  3'b111, 0, 81,    80};

        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 0);
        check("rst_done",   {31'd0, done}, 0);
        check("rst_plot",   {31'd0, vga_plot}, 0);
        check("rst_xycol",  {14'd0, vga_x, vga_y, vga_colour}, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_busy",  {31'd0, busy}, 0);

        for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // Reset during DRAW: abort after 30 pixels, nothing remembered
        v = '{1'b1, 1'b0, 1'b0, 8'd70, 7'd40, 3'b101, 0, 81, 80};
        model(v);
        @(negedge clk);
        start = 1'b1; curr_x_position = v.x; curr_y_position = v.y; colour_in = v.col;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 30; n++) @(negedge clk);
        resetn = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        check("midrst_plot", {31'd0, vga_plot}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        resetn = 1'b1;
        exp_q.delete();
        m_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", {31'd0, busy}, 0);

        v = '{1'b1, 1'b0, 1'b1, 8'd20, 7'd30, 3'b001, 0, 81, 80};
        run_cmd(v, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
